// File: rtl/data_mem_responder.sv
// Slow single-port data RAM slave: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then returns a registered response over valid/ready.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state, next_state;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_be;
  logic [31:0]         mem [DEPTH];

  logic                accept, access, retire, addr_err;
  logic [ADDR_W-1:0]   word_idx;

  assign accept   = (state == S_IDLE) && req_valid;
  assign access   = (state == S_WAIT) && (cnt == 4'd0);
  assign retire   = (state == S_RESP) && rsp_ready;
  // Misaligned, or any byte-address bit above the implemented capacity set.
  assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:ADDR_W+2] != '0);
  assign word_idx = lat_addr[ADDR_W+1:2];

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state; no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:  if (req_valid)     next_state = S_WAIT;
      S_WAIT:  if (cnt == 4'd0)   next_state = S_RESP;
      S_RESP:  if (rsp_ready)     next_state = S_IDLE;
      default:                    next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= WAIT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rsp_rdata <= (lat_we || addr_err) ? 32'd0 : mem[word_idx];
        rsp_err   <= addr_err;
      end else if (retire) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset, only the write is gated by it.
  always_ff @(posedge clk) begin
    if (!reset && access && lat_we && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule
